// File: rtl/uart_apb_tx_buffer.sv
// APB slave in front of the uart core: configuration registers, a transmit
// byte FIFO and a launch FSM that hands one byte at a time to the core.
module uart_apb_tx_buffer #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] BAUD_RST = 32'd115200,
  parameter logic [31:0] CLKF_RST = 32'd50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  din,
  output logic        tx_en,
  input  logic        tx_done,
  output logic [3:0]  frame_size,
  output logic [1:0]  parity_type,
  output logic        bclk_en,
  output logic [31:0] BAUD_RATE_TX,
  output logic [31:0] CLK_FREQ,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t          state_reg, state_next;
  logic [8:0]      ctrl_reg;
  logic [31:0]     baud_reg;
  logic [31:0]     clkf_reg;
  logic            overflow_reg;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [7:0]      din_reg;
  logic            sync1_reg, sync2_reg, sync3_reg;

  logic [2:0] addr;
  logic       access, wr, data_wr;
  logic       fifo_empty, fifo_full, pop, push_ok, done_rise, busy;
  logic       unused_paddr;

  assign addr         = paddr[4:2];
  assign unused_paddr = ^paddr[1:0];
  assign access       = psel & penable;
  assign wr           = access & pwrite;
  assign data_wr      = wr & (addr == 3'd0);

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign busy       = (state_reg != S_IDLE);
  assign pop        = (state_reg == S_IDLE) & ctrl_reg[0] & ~fifo_empty;
  // A same-cycle pop frees the slot the push needs, so a full FIFO still accepts it.
  assign push_ok    = data_wr & (~fifo_full | pop);
  assign done_rise  = sync2_reg & ~sync3_reg;

  // Registers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg     <= 9'h040;
      baud_reg     <= BAUD_RST;
      clkf_reg     <= CLKF_RST;
      overflow_reg <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          3'd2:    ctrl_reg <= pwdata[8:0];
          3'd3:    baud_reg <= pwdata;
          3'd4:    clkf_reg <= pwdata;
          default: ;
        endcase
      end
      if (data_wr && !push_ok)
        overflow_reg <= 1'b1;
      else if (wr && addr == 3'd1 && pwdata[3])
        overflow_reg <= 1'b0;
    end
  end

  // FIFO storage: no reset, registered read into din
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= pwdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      din_reg    <= 8'd0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        din_reg    <= mem[rd_ptr_reg];
      end
      count_reg <= count_reg + CW'(push_ok) - CW'(pop);
    end
  end

  // tx_done crosses from the core's domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= tx_done;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (pop) state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT:   if (done_rise) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    prdata = 32'd0;
    if (psel && !pwrite) begin
      case (addr)
        3'd1:    prdata = {16'd0, 8'(count_reg), 4'd0, overflow_reg, busy, fifo_full, fifo_empty};
        3'd2:    prdata = {23'd0, ctrl_reg};
        3'd3:    prdata = baud_reg;
        3'd4:    prdata = clkf_reg;
        default: prdata = 32'd0;
      endcase
    end
  end

  assign pready       = 1'b1;
  assign pslverr      = access & (addr > 3'd4);
  assign din          = din_reg;
  assign tx_en        = (state_reg == S_LAUNCH) & ~rst;
  assign frame_size   = ctrl_reg[6:3];
  assign parity_type  = ctrl_reg[2:1];
  assign bclk_en      = ctrl_reg[7];
  assign BAUD_RATE_TX = baud_reg;
  assign CLK_FREQ     = clkf_reg;
  assign irq          = fifo_empty & ctrl_reg[8] & ~busy;

endmodule

// File: tb/tb_uart_apb_tx_buffer.sv
// Scoreboard bench for uart_apb_tx_buffer: expected launch bytes are queued
// when written over APB and compared as tx_en pulses appear.
module tb_uart_apb_tx_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = 5'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  din;
  logic        tx_en;
  logic        tx_done = 1'b0;
  logic [3:0]  frame_size;
  logic [1:0]  parity_type;
  logic        bclk_en;
  logic [31:0] BAUD_RATE_TX, CLK_FREQ;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int tx_count = 0;
  int seen = 0;
  logic [7:0] obs_din [64];
  logic [7:0] exp_q [$];

  uart_apb_tx_buffer dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .din(din), .tx_en(tx_en), .tx_done(tx_done),
    .frame_size(frame_size), .parity_type(parity_type), .bclk_en(bclk_en),
    .BAUD_RATE_TX(BAUD_RATE_TX), .CLK_FREQ(CLK_FREQ), .irq(irq)
  );

  always #5 clk = ~clk;

  // Record every cycle tx_en is high; a stretched pulse shows up as extra launches
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      if (tx_count < 64) obs_din[tx_count] = din;
      $display("launch #%0d din=%02h", tx_count, din);
      tx_count = tx_count + 1;
    end
  end

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("apb wr addr=%02h data=%08h err=%0b", a, d, err);
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    $display("apb rd addr=%02h data=%08h err=%0b", a, d, err);
  endtask

  task automatic do_reset();
    rst = 1'b1; psel = 1'b0; penable = 1'b0; tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    seen = tx_count;
  endtask

  task automatic wait_launch(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (tx_count > seen) got = 1'b1;
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 tx_done = 1'b1;
    repeat (4) @(posedge clk);
    #1 tx_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic err;
    do_reset();
    checks++; if ({tx_en, irq, pslverr} !== 3'b000) begin failures++; $display("FAIL reset_outs got=%b exp=000", {tx_en, irq, pslverr}); end
    checks++; if (din !== 8'h00 || prdata !== 32'd0) begin failures++; $display("FAIL reset_din_prdata got=%h/%h exp=0/0", din, prdata); end
    checks++; if (frame_size !== 4'd8 || parity_type !== 2'd0 || bclk_en !== 1'b0) begin failures++; $display("FAIL reset_mirrors got=%h/%h/%b exp=8/0/0", frame_size, parity_type, bclk_en); end
    checks++; if (BAUD_RATE_TX !== 32'd115200 || CLK_FREQ !== 32'd50000000) begin failures++; $display("FAIL reset_baud_clk got=%0d/%0d exp=115200/50000000", BAUD_RATE_TX, CLK_FREQ); end
    apb_read(5'h08, rd, err);
    checks++; if (rd !== 32'h040 || err !== 1'b0) begin failures++; $display("FAIL reset_ctrl got=%h err=%b exp=00000040", rd, err); end
    apb_read(5'h0C, rd, err);
    checks++; if (rd !== 32'd115200) begin failures++; $display("FAIL reset_baud got=%0d exp=115200", rd); end
    apb_read(5'h10, rd, err);
    checks++; if (rd !== 32'd50000000) begin failures++; $display("FAIL reset_clkf got=%0d exp=50000000", rd); end
    apb_read(5'h04, rd, err);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=00000001", rd); end
  endtask

  task automatic test_single_launch();
    logic [31:0] rd;
    logic err;
    bit got;
    int n;
    do_reset();
    apb_write(5'h00, 32'hA5, err); exp_q.push_back(8'hA5);
    apb_read(5'h04, rd, err);
    checks++; if (rd !== 32'h100) begin failures++; $display("FAIL single_status_queued got=%h exp=00000100", rd); end
    repeat (5) @(negedge clk);
    checks++; if (tx_count !== seen) begin failures++; $display("FAIL single_no_launch got=%0d exp=%0d", tx_count, seen); end
    apb_write(5'h08, 32'h141, err);
    wait_launch(20, got);
    checks++;
    if (!got) begin failures++; $display("FAIL single_launch_timeout got=none exp=A5"); end
    else begin
      if (obs_din[seen] !== exp_q[0]) begin failures++; $display("FAIL single_din got=%h exp=%h", obs_din[seen], exp_q[0]); end
      void'(exp_q.pop_front()); seen++;
    end
    repeat (5) @(posedge clk);
    #1 tx_done = 1'b1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_busy got=%b exp=0", irq); end
    n = 0;
    while (n < 10 && irq !== 1'b1) begin @(posedge clk); #1; n++; end
    checks++; if (n != 3) begin failures++; $display("FAIL single_done_latency got=%0d exp=3", n); end
    repeat (3) @(posedge clk);
    #1 tx_done = 1'b0;
    apb_read(5'h04, rd, err);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL single_status_done got=%h exp=00000001", rd); end
    apb_write(5'h08, 32'h041, err);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_disabled got=%b exp=0", irq); end
    checks++; if (tx_count !== seen) begin failures++; $display("FAIL single_extra_launch got=%0d exp=%0d", tx_count, seen); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic err;
    do_reset();
    for (int i = 0; i < 9; i++) apb_write(5'h00, 32'(i), err);
    apb_read(5'h04, rd, err);
    checks++; if (rd !== 32'h80A) begin failures++; $display("FAIL overflow_status got=%h exp=0000080A", rd); end
    apb_write(5'h04, 32'h8, err);
    apb_read(5'h04, rd, err);
    checks++; if (rd !== 32'h802) begin failures++; $display("FAIL overflow_clear got=%h exp=00000802", rd); end
    checks++; if (tx_count !== seen) begin failures++; $display("FAIL overflow_no_launch got=%0d exp=%0d", tx_count, seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
    logic err;
    bit got;
    do_reset();
    for (int i = 0; i < 3; i++) begin apb_write(5'h00, 32'(bytes[i]), err); exp_q.push_back(bytes[i]); end
    apb_write(5'h08, 32'h001, err);
    for (int i = 0; i < 3; i++) begin
      wait_launch(20, got);
      checks++;
      if (!got) begin failures++; $display("FAIL b2b_launch_timeout idx=%0d got=none exp=%h", i, exp_q[0]); end
      else begin
        if (obs_din[seen] !== exp_q[0]) begin failures++; $display("FAIL b2b_din idx=%0d got=%h exp=%h", i, obs_din[seen], exp_q[0]); end
        void'(exp_q.pop_front()); seen++;
      end
      repeat (8) @(negedge clk);
      #1;
      checks++; if (tx_count !== seen) begin failures++; $display("FAIL b2b_early_launch idx=%0d got=%0d exp=%0d", i, tx_count, seen); end
      pulse_done();
    end
    apb_read(5'h04, rd, err);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL b2b_status got=%h exp=00000001", rd); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    logic err;
    bit got;
    do_reset();
    for (int i = 0; i < 8; i++) begin apb_write(5'h00, 32'(8'hB0 + i), err); exp_q.push_back(8'(8'hB0 + i)); end
    apb_write(5'h08, 32'h001, err);
    wait_launch(20, got);
    checks++;
    if (!got) begin failures++; $display("FAIL full_launch0_timeout got=none exp=B0"); end
    else begin
      if (obs_din[seen] !== exp_q[0]) begin failures++; $display("FAIL full_din0 got=%h exp=%h", obs_din[seen], exp_q[0]); end
      void'(exp_q.pop_front()); seen++;
    end
    apb_write(5'h00, 32'hC8, err); exp_q.push_back(8'hC8);
    // Done edge seen two edges after tx_done, FSM idle on the third, pop on the fourth
    @(posedge clk); #1 tx_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'hD9;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_done = 1'b0;
    exp_q.push_back(8'hD9);
    $display("apb wr addr=00 data=000000d9 (with pop)");
    wait_launch(20, got);
    checks++;
    if (!got) begin failures++; $display("FAIL full_launch1_timeout got=none exp=B1"); end
    else begin
      if (obs_din[seen] !== exp_q[0]) begin failures++; $display("FAIL full_din1 got=%h exp=%h", obs_din[seen], exp_q[0]); end
      void'(exp_q.pop_front()); seen++;
    end
    apb_read(5'h04, rd, err);
    checks++; if (rd !== 32'h806) begin failures++; $display("FAIL full_push_pop_status got=%h exp=00000806", rd); end
  endtask

  task automatic test_regs_unmapped();
    logic [31:0] rd;
    logic err;
    do_reset();
    apb_read(5'h14, rd, err);
    checks++; if (rd !== 32'd0 || err !== 1'b1) begin failures++; $display("FAIL unmapped_read got=%h err=%b exp=0 err=1", rd, err); end
    apb_write(5'h1C, 32'hFFFFFFFF, err);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL unmapped_write_err got=%b exp=1", err); end
    apb_read(5'h08, rd, err);
    checks++; if (rd !== 32'h040) begin failures++; $display("FAIL unmapped_ctrl_kept got=%h exp=00000040", rd); end
    apb_write(5'h0C, 32'd9600, err);
    apb_write(5'h10, 32'd100000000, err);
    checks++; if (BAUD_RATE_TX !== 32'd9600 || CLK_FREQ !== 32'd100000000) begin failures++; $display("FAIL cfg_mirror got=%0d/%0d exp=9600/100000000", BAUD_RATE_TX, CLK_FREQ); end
    apb_write(5'h08, 32'hFFFFFFFE, err);
    apb_read(5'h08, rd, err);
    checks++; if (rd !== 32'h1FE) begin failures++; $display("FAIL ctrl_readback got=%h exp=000001FE", rd); end
    checks++; if ({frame_size, parity_type, bclk_en, irq} !== 8'hFF) begin failures++; $display("FAIL ctrl_mirrors got=%h exp=ff", {frame_size, parity_type, bclk_en, irq}); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    logic err;
    bit got;
    do_reset();
    apb_write(5'h0C, 32'd9600, err);
    apb_write(5'h00, 32'h55, err); exp_q.push_back(8'h55);
    apb_write(5'h00, 32'h66, err); exp_q.push_back(8'h66);
    apb_write(5'h08, 32'h001, err);
    wait_launch(20, got);
    checks++;
    if (!got) begin failures++; $display("FAIL rstwait_launch_timeout got=none exp=55"); end
    else begin
      if (obs_din[seen] !== exp_q[0]) begin failures++; $display("FAIL rstwait_din got=%h exp=%h", obs_din[seen], exp_q[0]); end
      void'(exp_q.pop_front()); seen++;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({tx_en, irq} !== 2'b00 || din !== 8'h00) begin failures++; $display("FAIL rstwait_outs got=%b/%h exp=00/00", {tx_en, irq}, din); end
    checks++; if (BAUD_RATE_TX !== 32'd115200 || frame_size !== 4'd8) begin failures++; $display("FAIL rstwait_cfg got=%0d/%0d exp=115200/8", BAUD_RATE_TX, frame_size); end
    rst = 1'b0;
    exp_q.delete();
    apb_read(5'h04, rd, err);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rstwait_status got=%h exp=00000001", rd); end
    repeat (15) @(negedge clk);
    #1;
    checks++; if (tx_count !== seen) begin failures++; $display("FAIL rstwait_no_launch got=%0d exp=%0d", tx_count, seen); end
  endtask

  initial begin
    test_reset();
    test_single_launch();
    test_overflow();
    test_back_to_back();
    test_full_push_pop();
    test_regs_unmapped();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_apb_tx_buffer.md
Name: uart_apb_tx_buffer

Overview:
- APB slave placed directly upstream of the uart core.
- Holds the uart configuration registers (baud, clock frequency, frame size, parity, bclk enable) and a transmit byte FIFO.
- A launch FSM pops bytes one at a time and drives the core's din/tx_en. It waits for tx_done before sending the next byte.

Parameters:
DEPTH, 8, TX FIFO depth in bytes; power of 2, at least 2.
BAUD_RST, 115200, reset value of the BAUD register.
CLKF_RST, 50000000, reset value of the CLK_FREQ register.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
psel  in  1  APB select.
penable  in  1  APB enable.
pwrite  in  1  APB write.
paddr  in  5  APB byte address; only [4:2] are decoded.
pwdata  in  32  APB write data.
prdata  out  32  APB read data.
pready  out  1  constant 1 (no wait states).
pslverr  out  1  error for an unmapped address, valid in the access phase.
din  out  8  byte to the uart core.
tx_en  out  1  one-cycle launch pulse to the uart core.
tx_done  in  1  core done level; asynchronous to clk.
frame_size  out  4  mirror of CTRL[6:3].
parity_type  out  2  mirror of CTRL[2:1].
bclk_en  out  1  mirror of CTRL[7].
BAUD_RATE_TX  out  32  mirror of the BAUD register.
CLK_FREQ  out  32  mirror of the CLK_FREQ register.
irq  out  1  high when the FIFO is empty, CTRL[8]=1 and the FSM is IDLE.

Behaviour:
- Reset (rst=1 at a clock edge) returns every output and state element to its reset value:
  - prdata=0, pslverr=0, din=0, tx_en=0, irq=0.
  - CTRL=0x040, giving frame_size=8, parity 00, bclk_en 0, launch disabled.
  - BAUD=BAUD_RST, CLK_FREQ=CLKF_RST.
  - FIFO empty, overflow=0, FSM=IDLE.
  - Reset mid-transfer discards all queued bytes and abandons the byte in flight; tx_en is never asserted during reset.
- APB access phase is psel&penable. A write commits on that edge. Read data is combinational from the registers, valid in the access phase.
- Register map, by paddr[4:2]:
  - 0 DATA. Write pushes pwdata[7:0]. Read returns 0.
  - 1 STATUS (RO). Bits: [15:8] count, [3] overflow, [2] busy (FSM not IDLE), [1] full, [0] empty. Writing 1 to bit 3 clears overflow; other written bits are ignored.
  - 2 CTRL (RW). Bits: [0] launch enable, [2:1] parity, [6:3] frame_size, [7] bclk_en, [8] irq enable. Upper bits read 0.
  - 3 BAUD (RW, 32 bits).
  - 4 CLK_FREQ (RW, 32 bits).
  - 5–7 unmapped. Reads return 0 with pslverr=1; writes have no effect and return pslverr=1.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap; count width is log2(DEPTH)+1.
  - A push when full drops the byte, sets sticky overflow, and leaves count unchanged.
  - A push and pop in the same cycle leave count unchanged. When full, the pop frees a slot, so the push is accepted.
  - A pop when empty is impossible by construction.
- tx_done is passed through a 2-flop synchronizer; its rising edge is detected on the synchronized value.
- FSM:
  - IDLE → LAUNCH when launch enable=1 and the FIFO is not empty. On this transition, din is loaded with the head byte and the FIFO pops.
  - LAUNCH: tx_en=1 for exactly one cycle, then → WAIT.
  - WAIT: stay until a synchronized tx_done rising edge, then → IDLE.
  - Clearing launch enable during LAUNCH or WAIT does not abort the byte; it only blocks the next launch.
  - din holds its value from LAUNCH until the next load.
  - Minimum gap between tx_en pulses is 3 clk cycles plus the done latency.
- Config writes take effect on the next cycle, even mid-frame; software is responsible for writing config only when busy=0.

Test Plan:
- Reset, then read all registers → CTRL=0x040, BAUD=115200, CLK_FREQ=50000000, STATUS=0x00000001.
- Write DATA 0xA5 with launch enable=0 → count=1, no tx_en. Then write CTRL=0x041 → one tx_en pulse with din=0xA5. Pulse tx_done high 5 cycles later → busy clears 3 cycles after the edge, empty=1, irq only if CTRL[8] is set.
- Push DEPTH+1 bytes 0x00..0x08 with launch disabled → full=1, overflow=1, count=8. Write STATUS bit3=1 → overflow=0.
- Enable launch with 3 queued bytes 0x11, 0x22, 0x33 and echo tx_done after each tx_en → din order 0x11, 0x22, 0x33; no second tx_en before its done edge.
- With FIFO full, the FSM popping and an APB DATA write in the same cycle → write accepted, count unchanged, no overflow.
- Read/write paddr 0x14 → pslverr=1, prdata=0, no register changes. Assert rst during WAIT → outputs return to reset values the next cycle and the FIFO is empty.
